uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_rr_pick.sv | 48 ++++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path and its front-end arbiter.
// Holds the arbiter state encoding, the 2-bit UART mode codes understood by
// both the transmitter and the receiver, and a small sizing helper.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    // Arbiter state encoding, kept as plain constants so older RTL that
    // compares against raw state codes keeps working
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOAD      = 3'd1;
    localparam state_t ST_START     = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_GAP       = 3'd4;

    // UART frame formats shared by TX and RX
    localparam logic [1:0] MODE_8N1 = 2'b00;
    localparam logic [1:0] MODE_8E1 = 2'b01;
    localparam logic [1:0] MODE_8O1 = 2'b10;
    localparam logic [1:0] MODE_8N2 = 2'b11;

    // Requester index width; covers up to 8 requesters
    localparam int OWNER_W = 3;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side handshake and the transmitter-side strobe/data
// signals of the UART TX arbiter.
//   req/reqData/reqMode : requester level requests, bytes and modes
//   gnt/done/err        : one-hot grant and completion pulses, abort flag
//   owner/busy          : current owner index, arbiter activity
//   txEn/txMode/txData  : start strobe and frame contents to the transmitter
//   txDone              : frame-complete pulse from the transmitter
// Modports: master = arbiter side, slave = requesters + transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [8*NREQ-1:0]  reqData;
    logic [2*NREQ-1:0]  reqMode;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic [OWNER_W-1:0] owner;
    logic               busy;
    logic               txEn;
    logic [1:0]         txMode;
    logic [7:0]         txData;
    logic               txDone;

    modport master (
        input  req, reqData, reqMode, txDone,
        output gnt, done, err, owner, busy, txEn, txMode, txData
    );

    modport slave (
        output req, reqData, reqMode, txDone,
        input  gnt, done, err, owner, busy, txEn, txMode, txData
    );
endinterface

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// the pointer and wrapping modulo NREQ; the first set bit wins.
//   i_req    : request vector
//   i_ptr    : index searched first
//   o_valid  : at least one request present
//   o_onehot : one-hot winner
//   o_idx    : binary winner index
// ---------------------------------------------------------------------------
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [OWNER_W-1:0] i_ptr,
    output logic               o_valid,
    output logic [NREQ-1:0]    o_onehot,
    output logic [OWNER_W-1:0] o_idx
);

    logic [3:0]      w_cand;
    logic [NREQ-1:0] w_shift;

    // Walk the candidates ptr, ptr+1, ... with a manual wrap; shifting the
    // request vector avoids variable bit-selects of mismatched index width
    always_comb begin
        o_valid  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_cand   = '0;
        w_shift  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, i_ptr} + 4'(k);
            if (w_cand >= 4'(NREQ)) begin
                w_cand = w_cand - 4'(NREQ);
            end
            w_shift = i_req >> w_cand;
            if (!o_valid && w_shift[0]) begin
                o_valid  = 1'b1;
                o_onehot = NREQ'(1) << w_cand;
                o_idx    = w_cand[OWNER_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter that lets NREQ requesters share one UART transmitter.
// Grants one byte at a time, strobes the transmitter, waits for its done
// pulse (or aborts after TIMEOUT cycles), then enforces an idle gap.
//   i_sclk : system clock, rising edge
//   i_sclr : synchronous active-high reset
//   bus    : requester and transmitter signals (master modport)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int GAP_CYC = 16,
    parameter int TIMEOUT = 200000
) (
    input  logic               i_sclk,
    input  logic               i_sclr,
    uart_tx_arbiter_if.master  bus
);

    // One counter serves both the timeout and the gap, so it must hold the
    // larger of the two limits
    localparam int CNT_MAX = maxOf(TIMEOUT, GAP_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             r_state;
    logic [OWNER_W-1:0] r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic [OWNER_W-1:0] r_owner;
    logic [7:0]         r_txData;
    logic [1:0]         r_txMode;

    logic               w_pickValid;
    logic [NREQ-1:0]    w_pickOnehot;
    logic [OWNER_W-1:0] w_pickIdx;
    logic               w_grant;
    logic               w_timeout;
    logic               w_gapEnd;
    logic               w_frameEnd;

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_valid  (w_pickValid),
        .o_onehot (w_pickOnehot),
        .o_idx    (w_pickIdx)
    );

    // Pulse outputs are decoded from state and masked by reset so that a
    // reset cycle never shows a grant, start strobe or completion
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_gapEnd   = (r_cnt == CNT_W'(GAP_CYC));
    assign w_grant    = !i_sclr && (r_state == ST_IDLE) && w_pickValid;
    assign w_frameEnd = !i_sclr && (r_state == ST_WAIT_DONE) && (bus.txDone || w_timeout);

    assign bus.gnt    = w_grant ? w_pickOnehot : '0;
    assign bus.done   = w_frameEnd ? (NREQ'(1) << r_owner) : '0;
    assign bus.err    = w_frameEnd && !bus.txDone;
    assign bus.txEn   = !i_sclr && (r_state == ST_START);
    assign bus.owner  = r_owner;
    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.txData = r_txData;
    assign bus.txMode = r_txMode;

    // Main sequencer. The GAP state counts 0..GAP_CYC so that TX_EN of the
    // next frame lands GAP_CYC+4 cycles after the previous TX_DONE
    always_ff @(posedge i_sclk) begin
        if (i_sclr) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_owner  <= '0;
            r_txData <= '0;
            r_txMode <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pickValid) begin
                        r_owner  <= w_pickIdx;
                        r_txData <= 8'(bus.reqData >> {w_pickIdx, 3'b000});
                        r_txMode <= 2'(bus.reqMode >> {w_pickIdx, 1'b0});
                        r_ptr    <= (w_pickIdx == OWNER_W'(NREQ - 1)) ? '0 : w_pickIdx + 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_START;
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (bus.txDone || w_timeout) begin
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_gapEnd) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NREQ=4, GAP_CYC=16, TIMEOUT=50).
// Expected grants and completions are queued when stimulus is driven and
// popped by a negedge monitor whenever the arbiter pulses GNT or DONE.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ    = 4;
    localparam int GAP_CYC = 16;
    localparam int TIMEOUT = 50;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [1:0] mode;
    } gntExp_t;

    typedef struct {
        int idx;
        bit err;
    } doneExp_t;

    logic clk;
    logic sclr;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    gntExp_t  gntQ[$];
    doneExp_t doneQ[$];
    int         expOwner   = 0;
    logic [7:0] expData    = '0;
    logic [1:0] expMode    = '0;
    int         lastGntCyc = 0;
    int         fairOrder[5] = '{0, 1, 2, 3, 0};

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_sclk (clk),
        .i_sclr (sclr),
        .bus    (bus)
    );

    // Free-running clock and a cycle index that is stable at every negedge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Hard stop in case something stalls beyond every bounded wait
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: every pulse from the arbiter is matched against the queues
    always @(negedge clk) begin : monitor
        int       pulses;
        gntExp_t  g;
        doneExp_t d;
        pulses = int'(bus.gnt != '0) + int'(bus.txEn) + int'(bus.done != '0);
        if (pulses != 0) checkOutput("onePulse", pulses, 1);
        if (bus.gnt != '0) begin
            if (gntQ.size() == 0) begin
                checkOutput("gntUnexpected", bus.gnt, 0);
            end else begin
                g = gntQ.pop_front();
                checkOutput("gntWinner", bus.gnt, 32'(1) << g.idx);
                expOwner   = g.idx;
                expData    = g.data;
                expMode    = g.mode;
                lastGntCyc = cyc;
            end
        end
        if (bus.txEn) begin
            checkOutput("txData", bus.txData, expData);
            checkOutput("txMode", bus.txMode, expMode);
            checkOutput("owner", bus.owner, expOwner);
            checkOutput("txEnLatency", cyc - lastGntCyc, 2);
        end
        if (bus.done != '0) begin
            if (doneQ.size() == 0) begin
                checkOutput("doneUnexpected", bus.done, 0);
            end else begin
                d = doneQ.pop_front();
                checkOutput("doneOwner", bus.done, 32'(1) << d.idx);
                checkOutput("doneErr", bus.err, d.err);
                checkOutput("txDataHeld", bus.txData, expData);
            end
        end else if (bus.err) begin
            checkOutput("errWithoutDone", bus.err, 0);
        end
    end

    // Inputs change only here, 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raiseReq(input int idx, input logic [7:0] data, input logic [1:0] mode);
        bus.req[idx]              = 1'b1;
        bus.reqData[idx*8 +: 8]   = data;
        bus.reqMode[idx*2 +: 2]   = mode;
    endtask

    task automatic expectGrant(input int idx, input logic [7:0] data, input logic [1:0] mode);
        gntExp_t g;
        g.idx  = idx;
        g.data = data;
        g.mode = mode;
        gntQ.push_back(g);
    endtask

    task automatic waitGnt();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("waitGnt", 0, 1);
        tick();
    endtask

    task automatic waitTxEn(output int enCyc);
        enCyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.txEn) begin
                enCyc = cyc;
                break;
            end
        end
        if (enCyc < 0) checkOutput("waitTxEn", 0, 1);
    endtask

    task automatic waitIdle(output int idleCyc);
        idleCyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idleCyc = cyc;
                break;
            end
        end
        if (idleCyc < 0) checkOutput("waitIdle", 0, 1);
    endtask

    // Plays the transmitter for one frame: waits for TX_EN, queues the
    // expected completion, pulses TX_DONE doneDelay cycles later (0 = never)
    task automatic applyStimulus(input int expIdx, input int doneDelay, input bit expErr,
                                 output int enCyc, output int doneCyc);
        doneExp_t d;
        waitTxEn(enCyc);
        d.idx = expIdx;
        d.err = expErr;
        doneQ.push_back(d);
        doneCyc = -1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            bus.txDone = (k == doneDelay);
            @(negedge clk);
            if (bus.done != '0) begin
                doneCyc = cyc;
                break;
            end
        end
        tick();
        bus.txDone = 1'b0;
        if (doneCyc < 0) checkOutput("waitDone", 0, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Gnt"},    bus.gnt,    0);
        checkOutput({tag, "Done"},   bus.done,   0);
        checkOutput({tag, "Err"},    bus.err,    0);
        checkOutput({tag, "Owner"},  bus.owner,  0);
        checkOutput({tag, "Busy"},   bus.busy,   0);
        checkOutput({tag, "TxEn"},   bus.txEn,   0);
        checkOutput({tag, "TxMode"}, bus.txMode, 0);
        checkOutput({tag, "TxData"}, bus.txData, 0);
    endtask

    initial begin
        int en1, dn1, en2, dn2, idleCyc;

        sclr        = 1'b1;
        bus.req     = '0;
        bus.reqData = '0;
        bus.reqMode = '0;
        bus.txDone  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sclr = 1'b0;
        @(negedge clk);
        checkResetValues("rst");

        $display("[TB] TX_DONE while idle");
        tick();
        bus.txDone = 1'b1;
        @(negedge clk);
        checkOutput("doneIdle", bus.done, 0);
        tick();
        bus.txDone = 1'b0;

        $display("[TB] single request");
        raiseReq(0, 8'h55, 2'b01);
        expectGrant(0, 8'h55, 2'b01);
        waitGnt();
        bus.req = '0;
        applyStimulus(0, 5, 1'b0, en1, dn1);
        checkOutput("singleDoneLat", dn1 - en1, 5);
        waitIdle(idleCyc);

        $display("[TB] fairness with all requests held");
        tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        for (int i = 0; i < NREQ; i++) raiseReq(i, 8'hA0 + 8'(i), 2'(i));
        for (int i = 0; i < 5; i++) expectGrant(fairOrder[i], 8'hA0 + 8'(fairOrder[i]), 2'(fairOrder[i]));
        for (int i = 0; i < 5; i++) applyStimulus(fairOrder[i], 3, 1'b0, en1, dn1);
        bus.req = '0;
        waitIdle(idleCyc);

        $display("[TB] timeout abort");
        tick();
        raiseReq(1, 8'h3C, 2'b10);
        expectGrant(1, 8'h3C, 2'b10);
        waitGnt();
        bus.req = '0;
        applyStimulus(1, 0, 1'b1, en1, dn1);
        checkOutput("timeoutLat", dn1 - en1, TIMEOUT);
        waitIdle(idleCyc);
        checkOutput("gapToIdle", idleCyc - dn1, GAP_CYC + 2);

        $display("[TB] TX_DONE on the timeout cycle");
        tick();
        raiseReq(2, 8'hC3, 2'b11);
        expectGrant(2, 8'hC3, 2'b11);
        waitGnt();
        bus.req = '0;
        applyStimulus(2, TIMEOUT, 1'b0, en1, dn1);
        checkOutput("collisionLat", dn1 - en1, TIMEOUT);
        waitIdle(idleCyc);

        $display("[TB] back-to-back requests and gap");
        tick();
        raiseReq(3, 8'h11, 2'b00);
        raiseReq(0, 8'h22, 2'b01);
        expectGrant(3, 8'h11, 2'b00);
        expectGrant(0, 8'h22, 2'b01);
        applyStimulus(3, 4, 1'b0, en1, dn1);
        bus.req[3] = 1'b0;
        applyStimulus(0, 4, 1'b0, en2, dn2);
        bus.req = '0;
        checkOutput("gapTxEnSpacing", en2 - dn1, GAP_CYC + 4);
        waitIdle(idleCyc);

        $display("[TB] reset during WAIT_DONE");
        tick();
        raiseReq(2, 8'h5A, 2'b01);
        expectGrant(2, 8'h5A, 2'b01);
        waitGnt();
        bus.req = '0;
        waitTxEn(en1);
        repeat (3) tick();
        sclr       = 1'b1;
        bus.txDone = 1'b1;
        tick();
        sclr       = 1'b0;
        bus.txDone = 1'b0;
        @(negedge clk);
        checkResetValues("midRst");
        tick();
        for (int i = 0; i < NREQ; i++) raiseReq(i, 8'h70 + 8'(i), 2'(i));
        expectGrant(0, 8'h70, 2'b00);
        waitGnt();
        bus.req = '0;
        applyStimulus(0, 2, 1'b0, en1, dn1);
        waitIdle(idleCyc);

        checkOutput("gntQEmpty", gntQ.size(), 0);
        checkOutput("doneQEmpty", doneQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
